// File: rtl/bbs_pkg.sv
// Shared types and constants for the bbs32 reader: word width, release timing and FSM states.
package bbs_pkg;

  localparam int unsigned BBS_WORD_W             = 32;
  localparam int unsigned BBS_REL_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWaitClr = 3'd2,
    StWaitRes = 3'd3,
    StRelease = 3'd4
  } bbs_rd_state_t;

endpackage

// File: rtl/bbs_result_fifo.sv
// Small synchronous FIFO buffering bbs32 result words; power-of-two depth, pointers wrap naturally.
module bbs_result_fifo
  import bbs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [BBS_WORD_W-1:0]   push_data,
  input  logic                    pop,
  output logic [BBS_WORD_W-1:0]   head,
  output logic                    not_empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

  logic [BBS_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q;
  logic                  do_pop;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == FullLvl);
  assign do_pop    = pop && not_empty;
  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !do_pop) begin
        level_q <= level_q + (AW + 1)'(1);
      end else if (!push && do_pop) begin
        level_q <= level_q - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

endmodule

// File: rtl/bbs32_reader.sv
// Drives the bbs32 start/result_valid handshake and streams each result word into a pop FIFO.
module bbs32_reader
  import bbs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REL_CYCLES = BBS_REL_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BBS_WORD_W-1:0]        cfg_seed,
  input  logic [BBS_WORD_W-1:0]        cfg_p,
  input  logic [BBS_WORD_W-1:0]        cfg_q,
  input  logic                         cfg_load,
  input  logic                         cfg_reseed,
  input  logic                         enable,
  output logic [BBS_WORD_W-1:0]        bbs_seed,
  output logic [BBS_WORD_W-1:0]        bbs_p,
  output logic [BBS_WORD_W-1:0]        bbs_q,
  output logic                         bbs_start,
  output logic                         bbs_keep_m,
  output logic                         bbs_use_xnext,
  input  logic [BBS_WORD_W-1:0]        bbs_result,
  input  logic                         bbs_result_valid,
  input  logic                         bbs_m_valid,
  output logic                         pop_valid,
  output logic [BBS_WORD_W-1:0]        pop_data,
  input  logic                         pop_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy,
  output logic                         cfg_valid
);

  localparam int unsigned RelW = (REL_CYCLES > 0) ? $clog2(REL_CYCLES + 1) : 1;

  bbs_rd_state_t         state_q, state_d;
  logic [RelW-1:0]       rel_cnt_q, rel_cnt_d;
  logic [BBS_WORD_W-1:0] seed_stg_q, seed_stg_d;
  logic [BBS_WORD_W-1:0] p_stg_q, p_stg_d;
  logic [BBS_WORD_W-1:0] q_stg_q, q_stg_d;
  logic                  need_m_q, need_m_d;
  logic                  need_seed_q, need_seed_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic [BBS_WORD_W-1:0] seed_out_q, seed_out_d;
  logic [BBS_WORD_W-1:0] p_out_q, p_out_d;
  logic [BBS_WORD_W-1:0] q_out_q, q_out_d;
  logic                  start_q, start_d;
  logic                  keep_m_q, keep_m_d;
  logic                  use_xnext_q, use_xnext_d;
  logic                  push;
  logic                  fifo_full;

  always_comb begin
    state_d     = state_q;
    rel_cnt_d   = rel_cnt_q;
    seed_stg_d  = seed_stg_q;
    p_stg_d     = p_stg_q;
    q_stg_d     = q_stg_q;
    need_m_d    = need_m_q;
    need_seed_d = need_seed_q;
    cfg_valid_d = cfg_valid_q;
    seed_out_d  = seed_out_q;
    p_out_d     = p_out_q;
    q_out_d     = q_out_q;
    start_d     = start_q;
    keep_m_d    = keep_m_q;
    use_xnext_d = use_xnext_q;
    push        = 1'b0;

    if (cfg_load) begin
      seed_stg_d  = cfg_seed;
      p_stg_d     = cfg_p;
      q_stg_d     = cfg_q;
      cfg_valid_d = 1'b1;
    end else if (cfg_reseed) begin
      seed_stg_d = cfg_seed;
    end

    unique case (state_q)
      StIdle: begin
        if (enable && cfg_valid_q && !fifo_full) state_d = StIssue;
      end
      StIssue: begin
        seed_out_d = seed_stg_q;
        p_out_d    = p_stg_q;
        q_out_d    = q_stg_q;
        start_d    = 1'b1;
        // A bbs32 that has lost M (e.g. after its own reset) must recompute it.
        if (need_m_q || !bbs_m_valid) begin
          keep_m_d    = 1'b0;
          use_xnext_d = 1'b0;
        end else if (need_seed_q) begin
          keep_m_d    = 1'b1;
          use_xnext_d = 1'b0;
        end else begin
          keep_m_d    = 1'b1;
          use_xnext_d = 1'b1;
        end
        need_m_d    = 1'b0;
        need_seed_d = 1'b0;
        state_d     = StWaitClr;
      end
      StWaitClr: begin
        if (!bbs_result_valid) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (bbs_result_valid) begin
          push      = 1'b1;
          start_d   = 1'b0;
          rel_cnt_d = RelW'(REL_CYCLES);
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (rel_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          rel_cnt_d = rel_cnt_q - RelW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Config pulses override the clear performed in ISSUE.
    if (cfg_load) begin
      need_m_d    = 1'b1;
      need_seed_d = 1'b1;
    end else if (cfg_reseed) begin
      need_seed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rel_cnt_q   <= '0;
      seed_stg_q  <= '0;
      p_stg_q     <= '0;
      q_stg_q     <= '0;
      need_m_q    <= 1'b1;
      need_seed_q <= 1'b1;
      cfg_valid_q <= 1'b0;
      seed_out_q  <= '0;
      p_out_q     <= '0;
      q_out_q     <= '0;
      start_q     <= 1'b0;
      keep_m_q    <= 1'b0;
      use_xnext_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rel_cnt_q   <= rel_cnt_d;
      seed_stg_q  <= seed_stg_d;
      p_stg_q     <= p_stg_d;
      q_stg_q     <= q_stg_d;
      need_m_q    <= need_m_d;
      need_seed_q <= need_seed_d;
      cfg_valid_q <= cfg_valid_d;
      seed_out_q  <= seed_out_d;
      p_out_q     <= p_out_d;
      q_out_q     <= q_out_d;
      start_q     <= start_d;
      keep_m_q    <= keep_m_d;
      use_xnext_q <= use_xnext_d;
    end
  end

  assign bbs_seed      = seed_out_q;
  assign bbs_p         = p_out_q;
  assign bbs_q         = q_out_q;
  assign bbs_start     = start_q;
  assign bbs_keep_m    = keep_m_q;
  assign bbs_use_xnext = use_xnext_q;
  assign busy          = (state_q != StIdle);
  assign cfg_valid     = cfg_valid_q;

  bbs_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bbs_result),
    .pop       (pop_valid && pop_ready),
    .head      (pop_data),
    .not_empty (pop_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_bbs32_reader.sv
// Bench for bbs32_reader: behavioural bbs32 responder plus a word-stream reference scoreboard.
module tb_bbs32_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_seed, cfg_p, cfg_q;
  logic        cfg_load, cfg_reseed, enable;
  logic [31:0] bbs_seed, bbs_p, bbs_q;
  logic        bbs_start, bbs_keep_m, bbs_use_xnext;
  logic [31:0] bbs_result;
  logic        bbs_result_valid, bbs_m_valid;
  logic        pop_valid;
  logic [31:0] pop_data;
  logic        pop_ready, pop_ready_drv;
  bit          coincide = 1'b0;
  bit          rv_first = 1'b0;
  logic [2:0]  fifo_level;
  logic        busy, cfg_valid;

  int          n_checks = 0;
  int          n_errors = 0;
  int          issue_count = 0;
  int          pop_count = 0;
  logic [31:0] exp_q [$];

  // Reference stream state, driven only by the bench's own cfg actions.
  logic [31:0] r_seed = '0, r_p = '0, r_q = '0;
  bit          r_pend_m = 1'b1, r_pend_seed = 1'b1;
  logic [63:0] r_m = '0, r_x = '0;

  always #5 clk = ~clk;

  // Coincide mode pops exactly in the cycle a fresh result is pushed.
  assign pop_ready = coincide ? rv_first : pop_ready_drv;

  bbs32_reader #(
    .FIFO_DEPTH (4),
    .REL_CYCLES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_seed         (cfg_seed),
    .cfg_p            (cfg_p),
    .cfg_q            (cfg_q),
    .cfg_load         (cfg_load),
    .cfg_reseed       (cfg_reseed),
    .enable           (enable),
    .bbs_seed         (bbs_seed),
    .bbs_p            (bbs_p),
    .bbs_q            (bbs_q),
    .bbs_start        (bbs_start),
    .bbs_keep_m       (bbs_keep_m),
    .bbs_use_xnext    (bbs_use_xnext),
    .bbs_result       (bbs_result),
    .bbs_result_valid (bbs_result_valid),
    .bbs_m_valid      (bbs_m_valid),
    .pop_valid        (pop_valid),
    .pop_data         (pop_data),
    .pop_ready        (pop_ready),
    .fifo_level       (fifo_level),
    .busy             (busy),
    .cfg_valid        (cfg_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 32 squarings mod m; bit i of the word is the LSB of x after step i+1.
  function automatic logic [31:0] bbs_gen(input logic [63:0] x0, input logic [63:0] m,
                                          output logic [63:0] xn);
    logic [63:0] x = x0;
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) begin
      x    = (x * x) % m;
      w[i] = x[0];
    end
    xn = x;
    return w;
  endfunction

  task automatic log_issue();
    logic [31:0] w;
    issue_count++;
    check_eq("issue_keep_m", bbs_keep_m, !r_pend_m);
    check_eq("issue_use_xnext", bbs_use_xnext, !r_pend_m && !r_pend_seed);
    check_eq("issue_seed", bbs_seed, r_seed);
    check_eq("issue_p", bbs_p, r_p);
    check_eq("issue_q", bbs_q, r_q);
    if (r_pend_m) r_m = r_p * r_q;
    if (r_pend_m || r_pend_seed) r_x = r_seed;
    w = bbs_gen(r_x, r_m, r_x);
    exp_q.push_back(w);
    r_pend_m    = 1'b0;
    r_pend_seed = 1'b0;
  endtask

  // Behavioural bbs32: result_valid stays high until the next start is seen.
  initial begin : responder
    int          st = 0;
    int          lat = 0;
    logic [63:0] rm = '0, rx = '0;
    bbs_result       = '0;
    bbs_result_valid = 1'b0;
    bbs_m_valid      = 1'b0;
    forever begin
      @(posedge clk); #1;
      rv_first = 1'b0;
      if (rst) begin
        st = 0;
        bbs_result_valid = 1'b0;
        bbs_m_valid      = 1'b0;
        rm = '0;
      end else begin
        case (st)
          0: if (bbs_start) begin
            bbs_result_valid = 1'b0;
            lat = $urandom_range(3, 9);
            log_issue();
            if (!bbs_keep_m) rm = bbs_p * bbs_q;
            if (!bbs_use_xnext) rx = {32'h0, bbs_seed};
            st = 1;
          end
          1: if (lat > 1) lat--;
          else begin
            if (rm == 0) bbs_result = 32'hdead_beef;
            else bbs_result = bbs_gen(rx, rm, rx);
            bbs_result_valid = 1'b1;
            bbs_m_valid      = (rm != 0);
            rv_first         = 1'b1;
            st = 2;
          end
          2: if (!bbs_start) st = 0;
          default: st = 0;
        endcase
      end
    end
  end

  initial begin : consumer
    forever begin
      @(negedge clk);
      if (!rst && pop_valid && pop_ready) begin
        pop_count++;
        if (exp_q.size() == 0) check_eq("pop_unexpected", 1, 0);
        else check_eq("pop_data", pop_data, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_cfg(input bit ld, input bit rs, input logic [31:0] s, input logic [31:0] p,
                        input logic [31:0] q);
    cfg_seed = s; cfg_p = p; cfg_q = q;
    cfg_load = ld; cfg_reseed = rs;
    if (ld) begin
      r_seed = s; r_p = p; r_q = q;
      r_pend_m = 1'b1; r_pend_seed = 1'b1;
    end else if (rs) begin
      r_seed = s; r_pend_seed = 1'b1;
    end
    tick();
    cfg_load = 1'b0; cfg_reseed = 1'b0;
  endtask

  task automatic wait_issue(input int target, input string tag);
    int n = 0;
    while (issue_count < target && n < 300) begin tick(); n++; end
    check_eq(tag, issue_count >= target, 1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (pop_count < target && n < 1000) begin tick(); n++; end
    check_eq(tag, pop_count >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (pop_valid && n < 300) begin tick(); n++; end
    check_eq(tag, pop_valid, 0);
  endtask

  initial begin : main
    int k;
    int p0;
    int n;
    rst = 1'b1; enable = 1'b0; pop_ready_drv = 1'b0;
    cfg_seed = '0; cfg_p = '0; cfg_q = '0; cfg_load = 1'b0; cfg_reseed = 1'b0;
    #12;
    check_eq("rst_start", bbs_start, 0);
    check_eq("rst_keep_m", bbs_keep_m, 0);
    check_eq("rst_use_xnext", bbs_use_xnext, 0);
    check_eq("rst_seed", bbs_seed, 0);
    check_eq("rst_p", bbs_p, 0);
    check_eq("rst_q", bbs_q, 0);
    check_eq("rst_pop_valid", pop_valid, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_valid", cfg_valid, 0);
    tick(); rst = 1'b0; tick(2);

    // No issue before the first cfg_load.
    enable = 1'b1;
    tick(20);
    check_eq("no_issue_without_cfg", issue_count, 0);
    check_eq("idle_without_cfg", busy, 0);
    enable = 1'b0;

    // Continuous stream, M=253, x0=3.
    do_cfg(1'b1, 1'b0, 32'd3, 32'd11, 32'd23);
    check_eq("cfg_valid_set", cfg_valid, 1);
    pop_ready_drv = 1'b1; enable = 1'b1;
    wait_pops(8, "stream_8_words");

    // Fill the FIFO with the consumer stalled.
    pop_ready_drv = 1'b0;
    tick(100);
    check_eq("full_level", fifo_level, 4);
    check_eq("full_pop_valid", pop_valid, 1);
    check_eq("full_no_5th_issue", issue_count, pop_count + 4);
    check_eq("full_idle", busy, 0);
    pop_ready_drv = 1'b1; tick(); pop_ready_drv = 1'b0;
    tick(60);
    check_eq("one_issue_after_pop", issue_count, pop_count + 4);
    check_eq("refull_level", fifo_level, 4);

    // Push and pop in the same cycle keep the level constant.
    pop_ready_drv = 1'b1; tick(); pop_ready_drv = 1'b0; coincide = 1'b1;
    p0 = pop_count;
    repeat (6) begin
      tick(10);
      check_eq("coincide_level", fifo_level, 3);
    end
    check_eq("coincide_pops", pop_count > p0 + 1, 1);
    coincide = 1'b0; pop_ready_drv = 1'b1;

    // Reseed while a word is in flight.
    wait_pops(pop_count + 4, "drain_before_reseed");
    k = issue_count;
    wait_issue(k + 1, "reseed_inflight_issue");
    tick();
    do_cfg(1'b0, 1'b1, 32'd5, 32'd0, 32'd0);
    check_eq("seed_hold", bbs_seed, 3);
    wait_issue(k + 2, "reseed_next_issue");
    check_eq("reseed_keep_m", bbs_keep_m, 1);
    check_eq("reseed_use_xnext", bbs_use_xnext, 0);
    check_eq("reseed_seed", bbs_seed, 5);
    wait_pops(pop_count + 3, "reseed_words");

    // cfg_load and cfg_reseed together behave as cfg_load.
    enable = 1'b0;
    wait_idle("idle_before_both");
    do_cfg(1'b1, 1'b1, 32'd7, 32'd19, 32'd23);
    k = issue_count;
    enable = 1'b1;
    wait_issue(k + 1, "both_issue");
    check_eq("both_keep_m", bbs_keep_m, 0);
    check_eq("both_p", bbs_p, 19);
    check_eq("both_q", bbs_q, 23);
    wait_pops(pop_count + 4, "both_words");

    // Reset with two words buffered and a third in flight.
    enable = 1'b0;
    wait_idle("idle_before_rst");
    wait_empty("empty_before_rst");
    pop_ready_drv = 1'b0; enable = 1'b1;
    n = 0;
    while (fifo_level != 3'd2 && n < 300) begin tick(); n++; end
    check_eq("level_before_rst", fifo_level, 2);
    k = issue_count;
    wait_issue(k + 1, "inflight_before_rst");
    tick();
    rst = 1'b1;
    #1;
    check_eq("arst_start", bbs_start, 0);
    check_eq("arst_level", fifo_level, 0);
    check_eq("arst_pop_valid", pop_valid, 0);
    check_eq("arst_cfg_valid", cfg_valid, 0);
    check_eq("arst_busy", busy, 0);
    exp_q.delete();
    r_pend_m = 1'b1; r_pend_seed = 1'b1;
    tick();
    rst = 1'b0;
    k = issue_count;
    tick(30);
    check_eq("no_issue_after_rst", issue_count, k);

    pop_ready_drv = 1'b1;
    do_cfg(1'b1, 1'b0, 32'd3, 32'd11, 32'd23);
    wait_pops(pop_count + 4, "post_rst_words");

    enable = 1'b0;
    wait_idle("final_idle");
    wait_empty("final_empty");
    tick(2);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
